// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared types and constants for the instruction-fetch stage:
//               fetch FSM state encoding, IF/ID pipeline record and the NOP
//               instruction word (addi x0,x0,0).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // Fetch FSM: REQ issues a request, WAIT awaits its response,
    // HOLD parks a response that arrived while decode was stalled.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_type;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register with write-enable and flush. Flush
//               loads a NOP bubble and wins over write-enable.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-high reset
//               i_flush - load {valid=0, pc=0, instr=NOP_INSTR}
//               i_we    - load i_d
//               i_d     - next IF/ID record
//               o_q     - current IF/ID record
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_flush,
    input  logic      i_we,
    input  if_id_type i_d,
    output if_id_type o_q
);

    if_id_type r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR};
        end else if (i_flush) begin
            r_q <= '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR};
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : if_id_register
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, a single-outstanding
//               instruction-memory handshake, a one-entry hold buffer for
//               responses that land during a stall, and the IF/ID register.
// Ports       : clk, reset          - clock / async active-high reset
//               PCWrite_n           - 1 = hold PC
//               if_id_Write_n       - 1 = hold IF/ID
//               is_control_hazard   - flush IF/ID, redirect to branch_target
//               branch_target       - redirect PC (low two bits ignored)
//               imem_req/addr       - fetch request and word address
//               imem_gnt            - request accepted this cycle
//               imem_rvalid/rdata   - response valid and instruction word
//               if_id_valid/pc/instr- IF/ID pipeline register contents
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite_n,
    input  logic        if_id_Write_n,
    input  logic        is_control_hazard,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    fetch_state_type r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_fetch_pc;
    logic            r_kill;
    logic [31:0]     r_hold_pc;
    logic [31:0]     r_hold_instr;

    fetch_state_type w_state_nxt;
    logic [31:0]     w_pc_nxt;
    logic [31:0]     w_fetch_pc_nxt;
    logic            w_kill_nxt;
    logic            w_hold_load;
    logic            w_deliver;
    logic [31:0]     w_deliver_pc;
    logic [31:0]     w_deliver_instr;
    logic            w_advance;
    logic            w_inflight;
    if_id_type       w_if_id_d;
    if_id_type       w_if_id_q;

    assign w_advance = ~PCWrite_n & ~if_id_Write_n;

    // A request is still in flight after this cycle if we are waiting and no
    // response came back, or if memory accepts a request right now.
    assign w_inflight = ((r_state == WAIT) & ~imem_rvalid) |
                        ((r_state == REQ)  &  imem_gnt);

    // Gated by reset so no request is presented while the memory side is
    // also being reset.
    assign imem_req  = (r_state == REQ) & ~reset;
    assign imem_addr = r_pc;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_kill_nxt      = r_kill;
        w_hold_load     = 1'b0;
        w_deliver       = 1'b0;
        w_deliver_pc    = r_fetch_pc;
        w_deliver_instr = imem_rdata;

        case (r_state)
            REQ: begin
                if (imem_gnt) begin
                    w_fetch_pc_nxt = r_pc;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else if (w_advance) begin
                        w_deliver   = 1'b1;
                        w_pc_nxt    = r_fetch_pc + 32'd4;
                        w_state_nxt = REQ;
                    end else begin
                        w_hold_load = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_advance) begin
                    w_deliver       = 1'b1;
                    w_deliver_pc    = r_hold_pc;
                    w_deliver_instr = r_hold_instr;
                    w_pc_nxt        = r_hold_pc + 32'd4;
                    w_state_nxt     = REQ;
                end
            end
            default: begin
                w_state_nxt = REQ;
            end
        endcase

        // Redirect overrides everything above. A response still owed by
        // memory (including one granted this very cycle from REQ) must be
        // swallowed before the next request, so it is marked for killing.
        if (is_control_hazard) begin
            w_pc_nxt    = branch_target & 32'hFFFF_FFFC;
            w_deliver   = 1'b0;
            w_hold_load = 1'b0;
            if (w_inflight) begin
                w_kill_nxt  = 1'b1;
                w_state_nxt = WAIT;
            end else begin
                w_kill_nxt  = 1'b0;
                w_state_nxt = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 32'd0;
            r_kill       <= 1'b0;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_kill     <= w_kill_nxt;
            if (w_hold_load) begin
                r_hold_pc    <= r_fetch_pc;
                r_hold_instr <= imem_rdata;
            end
        end
    end

    // When advancing without a new instruction the register takes a bubble:
    // valid drops but pc/instr keep their previous contents.
    always_comb begin
        w_if_id_d = '{valid: 1'b0, pc: w_if_id_q.pc, instr: w_if_id_q.instr};
        if (w_deliver) begin
            w_if_id_d = '{valid: 1'b1, pc: w_deliver_pc, instr: w_deliver_instr};
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_register (
        .clk     (clk),
        .rst     (reset),
        .i_flush (is_control_hazard),
        .i_we    (w_advance),
        .i_d     (w_if_id_d),
        .o_q     (w_if_id_q)
    );

    assign if_id_valid = w_if_id_q.valid;
    assign if_id_pc    = w_if_id_q.pc;
    assign if_id_instr = w_if_id_q.instr;

endmodule : fetch_stage
`default_nettype wire
